dpram_arbiter: RTL and testbench
================================

// Module: dpram_arbiter
// PURPOSE
//   Shares one single-port RAM between the two PowerPC bus interfaces (core A, core B) of the dual-core system.
//   Each side's one-cycle re/we pulse and word address (A31..A10) are latched as a pending request.
//   Pending requests are served round-robin through a small FSM that drives the RAM port.
//   Completion is returned per side as rdata plus a one-cycle ack pulse.
// PARAMETERS
//   AW       22  word-address width (matches the bus interface addr output)
//   DW       32  data width
//   RAM_LAT  1   RAM read latency in clk cycles (1..4); ram_rdata valid RAM_LAT cycles after the ram_en cycle
// PORTS
//   clk        in   1   system clock; all logic on posedge
//   rst_n      in   1   asynchronous active-low reset
//   a_re       in   1   core A read pulse (1 cycle, synchronous to clk)
//   a_we       in   1   core A write pulse (1 cycle)
//   a_addr     in   AW  core A word address, sampled with a_re/a_we
//   a_wdata    in   DW  core A write data, sampled with a_we
//   a_rdata    out  DW  core A read data; valid from a_ack, held until the next A read completes
//   a_ack      out  1   core A completion pulse (reads and writes)
//   a_ovf      out  1   sticky: A pulse arrived while A pending; cleared only by reset
//   b_*        --   --  identical set for core B (b_re, b_we, b_addr, b_wdata, b_rdata, b_ack, b_ovf)
//   ram_en     out  1   RAM access strobe, 1 cycle per access
//   ram_we     out  1   RAM write enable, qualified by ram_en
//   ram_addr   out  AW  RAM address
//   ram_wdata  out  DW  RAM write data
//   ram_rdata  in   DW  RAM read data
//   busy       out  1   FSM not in IDLE
// BEHAVIOUR
//   Reset: all outputs 0; FSM=IDLE; pend_a=pend_b=0; last_grant=B, so A wins the first tie.
//   Request latch per side:
//     - Pulse at cycle N: pend=1 at N+1, with addr, wdata and type captured.
//     - re and we in the same cycle: write wins; ovf is not set.
//     - Pulse while pend=1: ignored; ovf<=1.
//     - Pulse in the same cycle as that side's completion (ack cycle): accepted as a new request; no ovf.
//   FSM states: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//     - IDLE: if any pend, select a side and go to ISSUE.
//       Both pending: take the side != last_grant, then update last_grant.
//     - ISSUE (1 cycle): ram_en=1, ram_we=type, ram_addr/ram_wdata from the selected latch.
//     - WAIT: RAM_LAT cycles (counter counts RAM_LAT-1 down to 0); entered for writes too (uniform timing).
//     - DONE (1 cycle): read: x_rdata<=ram_rdata; x_ack=1 in the following cycle; pend cleared on the same edge.
//   Latency, isolated request:
//     - Pulse cycle 0, pend cycle 1, ram_en cycle 2, ack cycle 3+RAM_LAT+1 (cycle 5 for RAM_LAT=1).
//   Back-to-back service:
//     - Next grant is decided in IDLE, one cycle after DONE.
//     - Throughput: one access per RAM_LAT+3 cycles.
//   Fairness: with both sides continuously pending, grants alternate strictly A,B,A,B.
//   Timing discipline:
//     - Outputs registered; ram_addr/ram_wdata hold their value outside ISSUE.
//     - ack is never asserted for both sides in the same cycle.
//   Mid-operation reset: access is abandoned, ram_en drops immediately, no ack issued; pending requests lost.
// STRUCTURE
//   dual_core_defs.vh: FSM state localparams (IDLE/ISSUE/WAIT/DONE), GRANT_A/GRANT_B encodings, default AW/DW.
//   Sub-module ppc_req_latch (instantiated twice):
//     - holds pend, type, addr, wdata and the ovf logic
//     - set/clear priority: set wins
//   Top level: arbiter FSM, last_grant, latency counter, RAM-side registers, rdata/ack registers.
// TESTING
//   1 Single A read, RAM_LAT=1, RAM[0x10]=0xDEADBEEF: a_re at cycle 0 with a_addr=0x10
//     -> ram_en at cycle 2 with ram_we=0 -> a_ack at cycle 5 with a_rdata=0xDEADBEEF; b_ack stays 0.
//   2 Simultaneous a_we(addr 0x4, 0x11111111) and b_we(addr 0x4, 0x22222222) after reset
//     -> A issued first, then B -> RAM[0x4]=0x22222222 -> a_ack precedes b_ack by RAM_LAT+3 cycles.
//   3 Both sides re-request on each ack for 8 accesses -> grant order A,B,A,B,...; no ovf set.
//   4 Second a_re while pend_a=1 -> a_ovf=1 (sticky); only one ram_en for A;
//     a new a_re in A's ack cycle is accepted with a_ovf unchanged.
//   5 RAM_LAT=3 read -> ram_en at cycle 2, a_ack at cycle 7, data = RAM content.
//   6 rst_n low during WAIT -> ram_en, a_ack, busy all 0 immediately;
//     after release no ack for the lost request; a fresh request completes normally.

Source files
------------

// File: rtl/dpram_arbiter_pkg.sv
// ============================================================================
// dpram_arbiter_pkg : shared types and constants for the dual-port RAM arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

package dpram_arbiter_pkg;

  localparam int DEF_AW = 22;
  localparam int DEF_DW = 32;
  localparam int CNT_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;

  // Round-robin choice: a tie goes to the side that was not granted last.
  function automatic grant_e rr_pick(input logic pend_a, input logic pend_b,
                                     input grant_e last);
    if (pend_a && pend_b) begin
      return (last == GRANT_A) ? GRANT_B : GRANT_A;
    end
    return pend_a ? GRANT_A : GRANT_B;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dpram_arbiter_req_latch.sv
// ============================================================================
// dpram_arbiter_req_latch : one bus side's pending request (pend/type/addr/data/ovf)
// Revision 1.0
// ============================================================================
`default_nettype none

module dpram_arbiter_req_latch
  import dpram_arbiter_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          re_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          clr_i,
  output logic          pend_o,
  output logic          wr_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] wdata_o,
  output logic          ovf_o
);

  logic          pend_q, pend_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          ovf_q, ovf_d;
  logic          pulse;
  logic          accept;

  always_comb begin
    pulse   = re_i | we_i;
    accept  = pulse & ~pend_q;
    pend_d  = pend_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ovf_d   = ovf_q;
    // A new request takes priority over the completion clear.
    if (accept) begin
      pend_d  = 1'b1;
      wr_d    = we_i;
      addr_d  = addr_i;
      wdata_d = wdata_i;
    end else if (clr_i) begin
      pend_d = 1'b0;
    end
    if (pulse && pend_q) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ovf_q   <= ovf_d;
    end
  end

  assign pend_o  = pend_q;
  assign wr_o    = wr_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign ovf_o   = ovf_q;

endmodule

`default_nettype wire

// File: rtl/dpram_arbiter.sv
// ============================================================================
// dpram_arbiter : round-robin sharing of one single-port RAM between two cores
// Revision 1.0
// ============================================================================
`default_nettype none

module dpram_arbiter
  import dpram_arbiter_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int RAM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_re,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic [DW-1:0] a_rdata,
  output logic          a_ack,
  output logic          a_ovf,
  input  logic          b_re,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic [DW-1:0] b_rdata,
  output logic          b_ack,
  output logic          b_ovf,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RAM_LAT - 1);

  logic          pend_a, pend_b;
  logic          wr_a, wr_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          clr_a, clr_b;

  state_e           state_q, state_d;
  grant_e           sel_q, sel_d;
  grant_e           last_q, last_d;
  grant_e           grant;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ram_en_q, ram_en_d;
  logic             ram_we_q, ram_we_d;
  logic [AW-1:0]    ram_addr_q, ram_addr_d;
  logic [DW-1:0]    ram_wdata_q, ram_wdata_d;
  logic             a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic [DW-1:0]    a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

  assign clr_a = (state_q == ST_DONE) && (sel_q == GRANT_A);
  assign clr_b = (state_q == ST_DONE) && (sel_q == GRANT_B);

  dpram_arbiter_req_latch #(.AW(AW), .DW(DW)) u_req_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .re_i    (a_re),
    .we_i    (a_we),
    .addr_i  (a_addr),
    .wdata_i (a_wdata),
    .clr_i   (clr_a),
    .pend_o  (pend_a),
    .wr_o    (wr_a),
    .addr_o  (addr_a),
    .wdata_o (wdata_a),
    .ovf_o   (a_ovf)
  );

  dpram_arbiter_req_latch #(.AW(AW), .DW(DW)) u_req_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .re_i    (b_re),
    .we_i    (b_we),
    .addr_i  (b_addr),
    .wdata_i (b_wdata),
    .clr_i   (clr_b),
    .pend_o  (pend_b),
    .wr_o    (wr_b),
    .addr_o  (addr_b),
    .wdata_o (wdata_b),
    .ovf_o   (b_ovf)
  );

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    a_ack_d     = 1'b0;
    b_ack_d     = 1'b0;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    grant       = rr_pick(pend_a, pend_b, last_q);

    case (state_q)
      ST_IDLE: begin
        if (pend_a || pend_b) begin
          state_d  = ST_ISSUE;
          sel_d    = grant;
          last_d   = grant;
          ram_en_d = 1'b1;
          if (grant == GRANT_A) begin
            ram_we_d    = wr_a;
            ram_addr_d  = addr_a;
            ram_wdata_d = wdata_a;
          end else begin
            ram_we_d    = wr_b;
            ram_addr_d  = addr_b;
            ram_wdata_d = wdata_b;
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = CNT_LOAD;
      end
      // Writes also wait out the read latency so every access has the same length.
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (sel_q == GRANT_A) begin
          a_ack_d = 1'b1;
          if (!wr_a) begin
            a_rdata_d = ram_rdata;
          end
        end else begin
          b_ack_d = 1'b1;
          if (!wr_b) begin
            b_rdata_d = ram_rdata;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sel_q       <= GRANT_A;
      last_q      <= GRANT_B;
      cnt_q       <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      a_ack_q     <= a_ack_d;
      b_ack_q     <= b_ack_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
    end
  end

  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign a_ack     = a_ack_q;
  assign b_ack     = b_ack_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_dpram_arbiter.sv
// ============================================================================
// tb_dpram_arbiter : directed and random checks of dpram_arbiter against a bench model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_dpram_arbiter;

  localparam int AW  = 22;
  localparam int DW  = 32;
  localparam int LAT = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main DUT (RAM_LAT = 1) ----------------
  logic          a_re, a_we, b_re, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          a_ack, b_ack, a_ovf, b_ovf;
  logic          ram_en, ram_we, busy;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  dpram_arbiter #(.AW(AW), .DW(DW), .RAM_LAT(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .a_re(a_re), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_ack(a_ack), .a_ovf(a_ovf),
    .b_re(b_re), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_ack(b_ack), .b_ovf(b_ovf),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
  );

  // ---------------- second DUT (RAM_LAT = 3) ----------------
  logic          a3_re;
  logic [AW-1:0] a3_addr;
  logic [DW-1:0] a3_rdata, b3_rdata;
  logic          a3_ack, b3_ack, a3_ovf, b3_ovf;
  logic          ram3_en, ram3_we, busy3;
  logic [AW-1:0] ram3_addr;
  logic [DW-1:0] ram3_wdata, ram3_rdata;

  dpram_arbiter #(.AW(AW), .DW(DW), .RAM_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .a_re(a3_re), .a_we(1'b0), .a_addr(a3_addr), .a_wdata('0),
    .a_rdata(a3_rdata), .a_ack(a3_ack), .a_ovf(a3_ovf),
    .b_re(1'b0), .b_we(1'b0), .b_addr('0), .b_wdata('0),
    .b_rdata(b3_rdata), .b_ack(b3_ack), .b_ovf(b3_ovf),
    .ram_en(ram3_en), .ram_we(ram3_we), .ram_addr(ram3_addr),
    .ram_wdata(ram3_wdata), .ram_rdata(ram3_rdata), .busy(busy3)
  );

  // ---------------- RAM behaviour: data appears LAT cycles after ram_en and holds ----------------
  logic [31:0] ram1 [64];
  logic        r1_v = 1'b0;
  logic [31:0] r1_d = '0, r1_h = '0;
  always @(posedge clk) begin
    r1_v <= ram_en && !ram_we;
    r1_d <= ram1[ram_addr[5:0]];
    if (ram_en && ram_we) ram1[ram_addr[5:0]] = ram_wdata;
    if (r1_v) r1_h <= r1_d;
  end
  assign ram_rdata = r1_v ? r1_d : r1_h;

  logic [31:0] ram3 [64];
  logic [2:0]  r3_v = '0;
  logic [31:0] r3_d0 = '0, r3_d1 = '0, r3_d2 = '0, r3_h = '0;
  always @(posedge clk) begin
    r3_v  <= {r3_v[1:0], ram3_en && !ram3_we};
    r3_d0 <= ram3[ram3_addr[5:0]];
    r3_d1 <= r3_d0;
    r3_d2 <= r3_d1;
    if (ram3_en && ram3_we) ram3[ram3_addr[5:0]] = ram3_wdata;
    if (r3_v[2]) r3_h <= r3_d2;
  end
  assign ram3_rdata = r3_v[2] ? r3_d2 : r3_h;

  // ---------------- bookkeeping ----------------
  int n_chk  = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] initv(input int i);
    return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  // ---------------- transaction-level reference model ----------------
  // An access occupies ages 0..LAT+1 after its grant: age 0 strobes the RAM,
  // age LAT+1 is the last busy cycle, and the ack shows one cycle later.
  logic [1:0]    m_pend, m_typ, m_ovf, m_ack;
  logic [AW-1:0] m_addr [2];
  logic [31:0]   m_wd [2];
  logic [31:0]   m_rd [2];
  logic [31:0]   m_mem [64];
  int            m_last, m_side, m_age;
  logic          m_act, m_en, m_we;
  logic [AW-1:0] m_raddr;
  logic [31:0]   m_rwd;
  logic [1:0]    mp0, mrv, mrw;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend = '0; m_typ = '0; m_ovf = '0; m_ack = '0;
      m_addr[0] = '0; m_addr[1] = '0; m_wd[0] = '0; m_wd[1] = '0;
      m_rd[0] = '0; m_rd[1] = '0;
      m_last = 1; m_side = 0; m_age = 0;
      m_act = 1'b0; m_en = 1'b0; m_we = 1'b0; m_raddr = '0; m_rwd = '0;
    end else begin
      mp0   = m_pend;
      mrv   = {b_re | b_we, a_re | a_we};
      mrw   = {b_we, a_we};
      m_ack = '0;
      m_en  = 1'b0;
      m_we  = 1'b0;
      if (m_act) begin
        if (m_age == 0 && m_typ[m_side]) m_mem[m_raddr[5:0]] = m_rwd;
        if (m_age == LAT + 1) begin
          m_ack[m_side] = 1'b1;
          if (!m_typ[m_side]) m_rd[m_side] = m_mem[m_addr[m_side][5:0]];
          m_pend[m_side] = 1'b0;
          m_act = 1'b0;
        end else begin
          m_age++;
        end
      end else if (mp0 != 2'b00) begin
        if (mp0 == 2'b11) m_side = 1 - m_last;
        else              m_side = mp0[0] ? 0 : 1;
        m_last  = m_side;
        m_act   = 1'b1;
        m_age   = 0;
        m_en    = 1'b1;
        m_we    = m_typ[m_side];
        m_raddr = m_addr[m_side];
        m_rwd   = m_wd[m_side];
      end
      for (int k = 0; k < 2; k++) begin
        if (mrv[k]) begin
          if (mp0[k]) m_ovf[k] = 1'b1;
          else begin
            m_pend[k] = 1'b1;
            m_typ[k]  = mrw[k];
            m_addr[k] = (k == 0) ? a_addr : b_addr;
            m_wd[k]   = (k == 0) ? a_wdata : b_wdata;
          end
        end
      end
    end
  end

  // Per-cycle comparison of every main-DUT output against the model.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("a_ack",     32'(a_ack),     32'(m_ack[0]));
      chk("b_ack",     32'(b_ack),     32'(m_ack[1]));
      chk("a_rdata",   a_rdata,        m_rd[0]);
      chk("b_rdata",   b_rdata,        m_rd[1]);
      chk("a_ovf",     32'(a_ovf),     32'(m_ovf[0]));
      chk("b_ovf",     32'(b_ovf),     32'(m_ovf[1]));
      chk("busy",      32'(busy),      32'(m_act));
      chk("ram_en",    32'(ram_en),    32'(m_en));
      chk("ram_we",    32'(ram_we),    32'(m_we));
      chk("ram_addr",  32'(ram_addr),  32'(m_raddr));
      chk("ram_wdata", ram_wdata,      m_rwd);
      chk("ack_excl",  32'(a_ack & b_ack), 32'd0);
    end
  end

  // Event logs for the directed latency checks.
  int   en_q[$], enw_q[$], aack_q[$], back_q[$], en3_q[$], ack3_q[$];
  always @(negedge clk) begin
    if (ram_en)  begin en_q.push_back(cyc); enw_q.push_back(int'(ram_we)); end
    if (a_ack)   aack_q.push_back(cyc);
    if (b_ack)   back_q.push_back(cyc);
    if (ram3_en) en3_q.push_back(cyc);
    if (a3_ack)  ack3_q.push_back(cyc);
  end

  task automatic clear_logs();
    en_q.delete(); enw_q.delete(); aack_q.delete(); back_q.delete();
    en3_q.delete(); ack3_q.delete();
  endtask

  task automatic idle_inputs();
    a_re = 1'b0; a_we = 1'b0; b_re = 1'b0; b_we = 1'b0; a3_re = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n  = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
  endtask

  int c0;
  int ord[$];

  initial begin
    idle_inputs();
    a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0; a3_addr = '0;
    for (int i = 0; i < 64; i++) begin
      ram1[i] = initv(i); ram3[i] = initv(i); m_mem[i] = initv(i);
    end
    ram1[16] = 32'hDEAD_BEEF; m_mem[16] = 32'hDEAD_BEEF;
    ram3[32] = 32'hCAFE_F00D;

    // Reset state
    do_reset();
    chk("rst_busy", 32'(busy), 0);       chk("rst_ram_en", 32'(ram_en), 0);
    chk("rst_ram_we", 32'(ram_we), 0);   chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_a_ack", 32'(a_ack), 0);     chk("rst_b_ack", 32'(b_ack), 0);
    chk("rst_a_rdata", a_rdata, 0);      chk("rst_a_ovf", 32'(a_ovf), 0);
    chk("rst_b_ovf", 32'(b_ovf), 0);     chk("rst_busy3", 32'(busy3), 0);

    // T1: isolated read, RAM_LAT=1
    @(negedge clk); c0 = cyc; a_re = 1'b1; a_addr = 22'h10;
    @(negedge clk); a_re = 1'b0;
    repeat (8) @(negedge clk);
    chk("t1_en_count", en_q.size(), 1);
    if (en_q.size() == 1) begin
      chk("t1_en_cycle", en_q[0] - c0, 2);
      chk("t1_en_we", enw_q[0], 0);
    end
    chk("t1_ack_count", aack_q.size(), 1);
    if (aack_q.size() == 1) chk("t1_ack_cycle", aack_q[0] - c0, 5);
    chk("t1_rdata", a_rdata, 32'hDEAD_BEEF);
    chk("t1_model_rd", m_rd[0], 32'hDEAD_BEEF);
    chk("t1_b_ack_none", back_q.size(), 0);

    // T2: simultaneous writes to the same word after reset
    do_reset();
    @(negedge clk); c0 = cyc;
    a_we = 1'b1; a_addr = 22'h4; a_wdata = 32'h1111_1111;
    b_we = 1'b1; b_addr = 22'h4; b_wdata = 32'h2222_2222;
    @(negedge clk); idle_inputs();
    repeat (12) @(negedge clk);
    chk("t2_aack_count", aack_q.size(), 1);
    chk("t2_back_count", back_q.size(), 1);
    if (aack_q.size() == 1 && back_q.size() == 1) begin
      chk("t2_aack_cycle", aack_q[0] - c0, 5);
      chk("t2_ack_gap", back_q[0] - aack_q[0], LAT + 3);
    end
    chk("t2_ram4", ram1[4], 32'h2222_2222);

    // T3: both sides re-request on every ack -> strict alternation
    do_reset();
    @(negedge clk); ord.delete();
    a_re = 1'b1; a_addr = 22'h5; b_re = 1'b1; b_addr = 22'h6;
    for (int i = 0; i < 100 && ord.size() < 8; i++) begin
      @(negedge clk);
      a_re = a_ack; b_re = b_ack;
      if (a_ack) ord.push_back(0);
      if (b_ack) ord.push_back(1);
    end
    @(negedge clk); idle_inputs();
    chk("t3_acks_seen", (ord.size() >= 8) ? 1 : 0, 1);
    for (int i = 0; i < ord.size() && i < 8; i++) chk("t3_order", ord[i], i % 2);
    chk("t3_a_ovf", 32'(a_ovf), 0);
    chk("t3_b_ovf", 32'(b_ovf), 0);
    repeat (12) @(negedge clk);

    // T4: overflow on a second pulse, then acceptance in the ack cycle
    do_reset();
    @(negedge clk); c0 = cyc; a_re = 1'b1; a_addr = 22'h7;
    @(negedge clk);                                   // second pulse while pending
    @(negedge clk); a_re = 1'b0;
    repeat (3) @(negedge clk);                        // ack cycle c0+5
    chk("t4_ack_now", 32'(a_ack), 1);
    a_re = 1'b1; a_addr = 22'h8;
    @(negedge clk); a_re = 1'b0;
    repeat (10) @(negedge clk);
    chk("t4_ovf", 32'(a_ovf), 1);
    chk("t4_en_count", en_q.size(), 2);
    if (en_q.size() == 2) begin
      chk("t4_en0", en_q[0] - c0, 2);
      chk("t4_en1", en_q[1] - c0, 7);
    end
    chk("t4_ack_count", aack_q.size(), 2);
    if (aack_q.size() == 2) chk("t4_ack1", aack_q[1] - c0, 10);
    chk("t4_rdata", a_rdata, initv(8));

    // T5: RAM_LAT=3 read on the second instance
    do_reset();
    @(negedge clk); c0 = cyc; a3_re = 1'b1; a3_addr = 22'h20;
    @(negedge clk); a3_re = 1'b0;
    repeat (10) @(negedge clk);
    chk("t5_en_count", en3_q.size(), 1);
    if (en3_q.size() == 1) chk("t5_en_cycle", en3_q[0] - c0, 2);
    chk("t5_ack_count", ack3_q.size(), 1);
    if (ack3_q.size() == 1) chk("t5_ack_cycle", ack3_q[0] - c0, 7);
    chk("t5_rdata", a3_rdata, 32'hCAFE_F00D);
    chk("t5_ovf", 32'(a3_ovf | b3_ovf | b3_ack), 0);
    chk("t5_b_rdata", b3_rdata, 0);

    // T6: reset while the access is waiting on the RAM
    do_reset();
    @(negedge clk); c0 = cyc; a_re = 1'b1; a_addr = 22'h10;
    @(negedge clk); a_re = 1'b0;
    repeat (2) @(negedge clk);                        // cycle c0+3: WAIT
    chk("t6_busy_pre", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_ram_en", 32'(ram_en), 0);
    chk("t6_a_ack", 32'(a_ack), 0);
    chk("t6_busy", 32'(busy), 0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1; clear_logs();
    repeat (8) @(negedge clk);
    chk("t6_no_ack", aack_q.size(), 0);
    chk("t6_no_en", en_q.size(), 0);
    @(negedge clk); c0 = cyc; a_re = 1'b1; a_addr = 22'h10;
    @(negedge clk); a_re = 1'b0;
    repeat (8) @(negedge clk);
    chk("t6_fresh_ack", aack_q.size(), 1);
    if (aack_q.size() == 1) chk("t6_fresh_cycle", aack_q[0] - c0, 5);
    chk("t6_fresh_rdata", a_rdata, 32'hDEAD_BEEF);

    // Random traffic on both sides, checked every cycle by the model
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      a_re    = ($urandom_range(0, 5) == 0);
      a_we    = ($urandom_range(0, 7) == 0);
      b_re    = ($urandom_range(0, 5) == 0);
      b_we    = ($urandom_range(0, 7) == 0);
      a_addr  = AW'($urandom_range(0, 63));
      b_addr  = AW'($urandom_range(0, 63));
      a_wdata = $urandom;
      b_wdata = $urandom;
    end
    @(negedge clk); idle_inputs();
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
